apb_cmd_queue: RTL

Command queue and issuer that sits directly upstream of the APB master/slave top. It accepts write/read requests over a valid/ready handshake and buffers them in a small FIFO. It replays each request to the APB master's `add`/`wdata` command port, holding the command until the master reports `ready`. Read data is captured into a one-entry response buffer that is drained over a valid/ready handshake.

---
 rtl/apb_cmd_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/apb_cmd_queue.sv
// Request FIFO plus a small issuer FSM that replays queued writes/reads onto an
// APB master command port and parks read data in a one-entry response buffer.
module apb_cmd_queue #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_write_i,
    input  logic [DW-1:0]              req_wdata_i,
    output logic [1:0]                 add_o,
    output logic [DW-1:0]              wdata_o,
    input  logic                       ready_i,
    input  logic [DW-1:0]              rdata_i,
    output logic                       rsp_valid_o,
    output logic [DW-1:0]              rsp_data_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ADD_IDLE  = 2'b00;
    localparam logic [1:0] ADD_WRITE = 2'b11;
    localparam logic [1:0] ADD_READ  = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, RDCAP, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      add_q, add_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic            fifo_wr_q   [DEPTH];
    logic [DW-1:0]   fifo_data_q [DEPTH];

    logic            push;
    logic            pop;
    logic            head_wr;
    logic [DW-1:0]   head_data;

    // Readiness comes from the registered count, so a full FIFO refuses a push
    // even when the same edge pops an entry.
    assign req_ready_o = (count_q < DEPTH_C);
    assign push        = req_valid_i && req_ready_o;
    assign head_wr     = fifo_wr_q[rd_ptr_q];
    assign head_data   = fifo_data_q[rd_ptr_q];

    // NOTE: FIFO storage has no reset; the pointers and count define which
    // entries are live, so clearing the array would only add reset fan-out.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_wr_q[wr_ptr_q]   <= req_write_i;
            fifo_data_q[wr_ptr_q] <= req_wdata_i;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        add_d       = add_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        pop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A read at the head waits for the response buffer to empty.
                if (count_q != '0 && (head_wr || !rsp_valid_q)) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                    add_d   = head_wr ? ADD_WRITE : ADD_READ;
                    wdata_d = head_wr ? head_data : '0;
                end
            end
            ISSUE: begin
                if (ready_i) begin
                    state_d = (add_q == ADD_WRITE) ? GAP : RDCAP;
                    add_d   = ADD_IDLE;
                end
            end
            RDCAP: begin
                rsp_data_d  = rdata_i;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            add_q       <= ADD_IDLE;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            add_q       <= add_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign add_o       = add_q;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign count_o     = count_q;
    assign busy_o      = (state_q != IDLE) || (count_q != '0) || rsp_valid_q;

endmodule
